mul_result_collector: RTL and testbench

- Sits directly downstream of the 4x4 multiplier.
- Watches the multiplier's op_ready/product outputs and captures each completed product exactly once.
- Buffers captured products in a small FIFO and presents them on a valid/ready output port for the display/checker stage.
- Flags results that are lost because the buffer is full.

---
 rtl/mul_result_collector.sv | 129 ++++++++++++
 tb/tb_mul_result_collector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_collector.sv
// mul_result_collector: captures each rising edge of the multiplier's op_ready
// once, buffers the product in a small first-word-fall-through FIFO and
// presents it on a valid/ready port. Dropped captures set a sticky overflow.
// Optional running saturating sum of accepted products: define MUL_RES_ACC_EN.
module mul_result_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = 8,
    parameter int unsigned AW    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_ready,
    input  logic [PW-1:0]              product,
    input  logic                       clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PW-1:0]              out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [AW-1:0]              acc
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            op_ready_d;

    logic            cap_c;
    logic            full_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    logic [CW-1:0]   count_nxt_c;

    // Capture/push/pop decode; clr overrides every other action in its cycle
    always_comb begin
        cap_c       = op_ready & ~op_ready_d;
        full_c      = (count == CW'(DEPTH));
        pop_c       = out_valid & out_ready & ~clr;
        push_c      = cap_c & (~full_c | pop_c) & ~clr;
        drop_c      = cap_c & full_c & ~pop_c & ~clr;
        count_nxt_c = count;
        if (clr) begin
            count_nxt_c = '0;
        end else if (push_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    // Edge detector copy; keeps updating through clr so a held op_ready stays quiet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_ready_d <= 1'b0;
        end else begin
            op_ready_d <= op_ready;
        end
    end

    // Pointers, occupancy, valid flag and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count     <= count_nxt_c;
            out_valid <= (count_nxt_c != '0);
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_c) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTRW'(1);
                end
                if (drop_c) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads 0 while empty after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_c) begin
            mem[wr_ptr] <= product;
        end
    end

    // Fall-through head read straight from the storage registers
    assign out_data = mem[rd_ptr];

`ifdef MUL_RES_ACC_EN
    logic [AW:0] acc_sum_c;

    // Sum at one extra bit so the carry flags saturation
    always_comb begin
        acc_sum_c = {1'b0, acc} + (AW+1)'(product);
    end

    // Saturating accumulator of accepted pushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (push_c) begin
            acc <= acc_sum_c[AW] ? {AW{1'b1}} : acc_sum_c[AW-1:0];
        end
    end
`else
    assign acc = '0;
`endif

endmodule

// File: tb/tb_mul_result_collector.sv
// Directed bench for mul_result_collector with hand-computed expectations.
module tb_mul_result_collector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 8;
    localparam int unsigned AW    = 12;

    logic                   clk;
    logic                   rst;
    logic                   op_ready;
    logic [PW-1:0]          product;
    logic                   clr;
    logic                   out_valid;
    logic                   out_ready;
    logic [PW-1:0]          out_data;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [AW-1:0]          acc;

    int checks;
    int errors;

    mul_result_collector #(.DEPTH(DEPTH), .PW(PW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_ready  (op_ready),
        .product   (product),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [PW-1:0] p);
        op_ready = 1'b1;
        product  = p;
        step();
        op_ready = 1'b0;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        op_ready  = 1'b0;
        product   = '0;
        clr       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid",    32'(out_valid), 0);
        chk("rst_count",    32'(count),     0);
        chk("rst_overflow", 32'(overflow),  0);
        chk("rst_acc",      32'(acc),       0);
        chk("rst_data",     32'(out_data),  0);
        rst = 1'b1;
        step();
        step();

        // Single capture then pop
        op_ready = 1'b1; product = 8'd42;
        step();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data",  32'(out_data),  42);
        chk("single_count", 32'(count),     1);
        op_ready = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_count", 32'(count),     0);
        chk("single_pop_valid", 32'(out_valid), 0);

        // op_ready held for five cycles yields one entry
        op_ready = 1'b1; product = 8'd15;
        repeat (5) step();
        op_ready = 1'b0;
        step();
        chk("held_count", 32'(count),    1);
        chk("held_data",  32'(out_data), 15);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("held_drain", 32'(count), 0);

        // Overflow: fifth product dropped, FIFO keeps 1..4
        for (int i = 1; i <= 5; i++) pulse(PW'(i));
        chk("ovf_count", 32'(count),    4);
        chk("ovf_flag",  32'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("ovf_empty",  32'(count),     0);
        chk("ovf_sticky", 32'(overflow),  1);
        chk("ovf_valid",  32'(out_valid), 0);
        do_clr();
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_count",    32'(count),    0);

        // Full with simultaneous capture and pop
        for (int i = 1; i <= 4; i++) pulse(PW'(i));
        chk("full_count", 32'(count), 4);
        op_ready = 1'b1; product = 8'd99; out_ready = 1'b1;
        step();
        op_ready = 1'b0; out_ready = 1'b0;
        chk("fullsim_count",    32'(count),    4);
        chk("fullsim_overflow", 32'(overflow), 0);
        out_ready = 1'b1;
        chk("fullsim_d0", 32'(out_data), 2); step();
        chk("fullsim_d1", 32'(out_data), 3); step();
        chk("fullsim_d2", 32'(out_data), 4); step();
        chk("fullsim_d3", 32'(out_data), 99); step();
        out_ready = 1'b0;
        chk("fullsim_empty", 32'(count), 0);

        // clr discards a coincident capture; held op_ready does not re-capture
        pulse(8'd50);
        op_ready = 1'b1; product = 8'd7; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrcap_count", 32'(count), 0);
        step();
        chk("clrheld_count", 32'(count), 0);
        op_ready = 1'b0;
        step();

        // Empty with capture and out_ready together: no bypass
        out_ready = 1'b1; op_ready = 1'b1; product = 8'd33;
        step();
        op_ready = 1'b0;
        chk("nobypass_count", 32'(count),     1);
        chk("nobypass_valid", 32'(out_valid), 1);
        chk("nobypass_data",  32'(out_data),  33);
        step();
        out_ready = 1'b0;
        chk("nobypass_drain", 32'(count), 0);

`ifdef MUL_RES_ACC_EN
        // Accumulator: 225*18=4050, 19th push saturates at 4095
        do_clr();
        chk("acc_clr0", 32'(acc), 0);
        out_ready = 1'b1;
        pulse(8'd225);
        pulse(8'd225);
        chk("acc_450", 32'(acc), 450);
        for (int i = 0; i < 18; i++) pulse(8'd225);
        chk("acc_sat", 32'(acc), 4095);
        out_ready = 1'b0;
        do_clr();
        chk("acc_clr",       32'(acc),   0);
        chk("acc_clr_count", 32'(count), 0);
`else
        pulse(8'd200);
        chk("acc_off", 32'(acc), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`endif

        // Asynchronous reset mid-stream with two entries queued
        pulse(8'd11);
        pulse(8'd12);
        chk("prerst_count", 32'(count), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",    32'(out_valid), 0);
        chk("arst_count",    32'(count),     0);
        chk("arst_overflow", 32'(overflow),  0);
        chk("arst_acc",      32'(acc),       0);
        #3;
        rst = 1'b1;
        step();
        chk("post_rst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
